ifid_queue: RTL

// Decoupling queue between the fetch stage and the decode stage (the IF/ID boundary).

---
 rtl/ifid_queue_pkg.sv | 16 +
 rtl/ifid_queue_if.sv | 40 ++++
 rtl/ifid_queue.sv | 69 ++++++
 3 files changed

// File: rtl/ifid_queue_pkg.sv
// Shared types for the IF/ID decoupling queue: the buffered entry layout and
// the bubble instruction presented to decode while the queue is empty.
package ifid_queue_pkg;

  localparam int IFID_XLEN = 32;

  // addi x0,x0,0
  localparam logic [IFID_XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [IFID_XLEN-1:0] pc;
    logic [IFID_XLEN-1:0] pc_plus4;
    logic [IFID_XLEN-1:0] instr;
  } ifid_entry_t;

endpackage

// File: rtl/ifid_queue_if.sv
// IF/ID boundary bundle: fetch-side push channel, decode-side pop channel,
// the branch kill and the occupancy debug output.
interface ifid_queue_if
  import ifid_queue_pkg::*;
#(
  parameter int DEPTH = 2
) ();

  localparam int CW = $clog2(DEPTH) + 1;

  // Handshake: an entry moves on a clock edge where valid and ready are both
  // high and flush is low; neither ready depends combinationally on its valid.
  logic                 fetch_valid;
  logic [IFID_XLEN-1:0] instruction_IFID_in;
  logic [IFID_XLEN-1:0] PC_IFID_in;
  logic [IFID_XLEN-1:0] PC_plus4_IFID_in;
  logic                 fetch_ready;
  logic                 flush;
  logic                 id_ready;
  logic                 valid_IFID_out;
  logic [IFID_XLEN-1:0] instruction_IFID_out;
  logic [IFID_XLEN-1:0] PC_IFID_out;
  logic [IFID_XLEN-1:0] PC_plus4_IFID_out;
  logic [CW-1:0]        count_IFID;

  modport master (
    output fetch_valid, instruction_IFID_in, PC_IFID_in, PC_plus4_IFID_in,
    output flush, id_ready,
    input  fetch_ready, valid_IFID_out, instruction_IFID_out,
    input  PC_IFID_out, PC_plus4_IFID_out, count_IFID
  );

  modport slave (
    input  fetch_valid, instruction_IFID_in, PC_IFID_in, PC_plus4_IFID_in,
    input  flush, id_ready,
    output fetch_ready, valid_IFID_out, instruction_IFID_out,
    output PC_IFID_out, PC_plus4_IFID_out, count_IFID
  );

endinterface

// File: rtl/ifid_queue.sv
// Flat FIFO between fetch and decode; a taken branch (flush) empties it and an
// empty queue presents a NOP bubble with zeroed PCs.
module ifid_queue
  import ifid_queue_pkg::*;
#(
  parameter int                   DEPTH    = 2,
  parameter logic [IFID_XLEN-1:0] NOP_WORD = NOP_INSTR
) (
  input logic         clk,
  input logic         rst_n,
  ifid_queue_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  ifid_entry_t   mem [DEPTH];
  ifid_entry_t   head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  // Ready and valid come from the registered count only, so id_ready never
  // reaches fetch_ready combinationally and a full queue ignores input even
  // when a pop happens in the same cycle.
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign push  = bus.fetch_valid & ~full & ~bus.flush;
  assign pop   = ~empty & bus.id_ready & ~bus.flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Payload storage needs no reset: an empty queue masks it at the outputs.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{pc:       bus.PC_IFID_in,
                       pc_plus4: bus.PC_plus4_IFID_in,
                       instr:    bus.instruction_IFID_in};
    end
  end

  assign head = mem[rd_ptr];

  assign bus.fetch_ready          = ~full;
  assign bus.valid_IFID_out       = ~empty;
  assign bus.instruction_IFID_out = empty ? NOP_WORD : head.instr;
  assign bus.PC_IFID_out          = empty ? '0 : head.pc;
  assign bus.PC_plus4_IFID_out    = empty ? '0 : head.pc_plus4;
  assign bus.count_IFID           = count;

endmodule
